lamp_sequencer: RTL and testbench
=================================

# lamp_sequencer

Parametrised successor of the two-input lamp controller. A 2-bit mode selects one of four lamp behaviours, now across `N_LAMPS` outputs, with timed animation (chase, blink) driven by a programmable prescaler. The block sits between the panel mode inputs and the lamp drivers. It holds the lamp register, the step prescaler and the mode state machine.

## Interface
- `N_LAMPS`, default 4: number of lamp outputs; legal range ≥ 2.
- `DIV_W`, default 8: width of the step-period input.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mode` in 2: `00` IDLE, `01` FILL, `10` CHASE, `11` BLINK; sampled every edge.
- `div` in `DIV_W`: step period minus one; one animation step every `div`+1 cycles.
- `q` out `N_LAMPS`: lamp pattern, registered.
- `active` out 1: high in every state except IDLE, registered.
- `tick` out 1: step strobe, `(cnt >= div) && state != IDLE`, decoded from registers.

## Operation
- Internal state:
  - `state` (S_IDLE, S_FILL, S_CHASE, S_BLINK)
  - `cnt` (`DIV_W` bits)
  - `pos` (clog2(`N_LAMPS`) bits)
  - `phase` (1 bit)
- Reset, while `rst`=0: `state`=S_IDLE, `q`=0, `active`=0, `cnt`=0, `pos`=0, `phase`=0. Reset takes effect immediately, including mid-animation. Operation resumes on the first edge after `rst` rises.
- State transitions: each edge, `state` takes the state encoded by `mode`. Any state can go to any state.
- Mode entry: when sampled `mode` differs from `state`, the same edge clears `cnt`, `pos` and `phase`, and loads `q` with the entry pattern of the new state.
- S_IDLE: `q`=0, `active`=0, `cnt` held at 0.
- S_FILL: `q` all ones, steady; `cnt` runs but has no visible effect.
- S_CHASE: `q` = one-hot, `1 << pos`.
  - Entry pattern is `...0001`.
  - On each tick edge, `pos` increments; `N_LAMPS`-1 wraps to 0.
- S_BLINK: base pattern E has bit 0 and bit `N_LAMPS`-1 set, all other bits clear.
  - `q` = E when `phase`=0, ~E when `phase`=1.
  - Entry pattern is E.
  - `phase` toggles on each tick edge.
  - With `N_LAMPS`=2, q alternates `11`/`00`.
- Prescaler:
  - On an edge with `tick`=1, `cnt` returns to 0; otherwise `cnt` increments.
  - `div`=0 gives a tick every cycle.
  - If `div` is lowered below the current `cnt`, `tick` asserts immediately (`>=` compare). There is no wrap past the new limit.
  - A `div` change never restarts the animation.
- Simultaneous mode change and tick: mode entry wins. Counters clear and the entry pattern loads; there is no step.

## Timing
- Latency: `mode` to `q`/`active` is 1 cycle (registered).
- In CHASE and BLINK, each pattern is held exactly `div`+1 cycles, counting from the entry edge.
- `tick` is high during the last cycle of each step.
- A full chase period is `N_LAMPS`·(`div`+1) cycles. A full blink period is 2·(`div`+1) cycles.
- Reset assertion clears outputs asynchronously, with no clock needed.

## Structure
- Package `lamp_seq_pkg` holds:
  - the mode/state encodings (`MODE_IDLE`=2'b00, `MODE_FILL`=2'b01, `MODE_CHASE`=2'b10, `MODE_BLINK`=2'b11);
  - the state typedef.
- One sub-module, `lamp_prescaler`:
  - ports: `clk`, `rst`, `clr`, `div`, output `tick`;
  - parameter `DIV_W`;
  - owns `cnt`.
- Pattern generation and the state machine live in `lamp_sequencer`.

## Test plan
All scenarios use `N_LAMPS`=4.

- Reset mid-animation: in CHASE with `q`=0100, pull `rst` low between edges → `q`=0000, `active`=0, `tick`=0 immediately, before the next edge.
- FILL: `mode`=01 → after 1 edge `q`=1111, `active`=1, held for 20 cycles regardless of `div`.
- CHASE timing: `mode`=10, `div`=2 → `q` steps 0001, 0010, 0100, 1000, each for 3 cycles, then wraps to 0001 at cycle 12; `tick` high on cycles 3, 6, 9, 12.
- BLINK at `div`=0: `mode`=11 → `q` alternates 1001, 0110 every cycle, starting at 1001.
- Mode change restarts the animation: in CHASE at `q`=0100, set `mode`=11 for 1 cycle, then `mode`=10 → `q` shows 1001, then 0001, and `pos` restarts at 0.
- Div lowered mid-count: `div`=5, wait until `cnt`=3, set `div`=1 → `tick` high in that same cycle, the step occurs on the next edge, and the following steps are 2 cycles long. Then `mode`=00 → `q`=0000, `active`=0 after 1 edge.

Source files
------------

// File: rtl/lamp_sequencer_pkg.sv
// lamp_seq_pkg: shared encodings for the lamp sequencer.
//   MODE_* : 2-bit panel mode codes (also used as the state encoding)
//   state_t: state machine type, one state per mode
package lamp_seq_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_FILL  = 2'b01;
  localparam logic [1:0] MODE_CHASE = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  // States share the mode encoding so the sampled mode casts straight to
  // the state it selects.
  typedef enum logic [1:0] {
    S_IDLE  = MODE_IDLE,
    S_FILL  = MODE_FILL,
    S_CHASE = MODE_CHASE,
    S_BLINK = MODE_BLINK
  } state_t;

endpackage

// File: rtl/lamp_prescaler.sv
// lamp_prescaler: animation step prescaler.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear of the step counter (wins over counting)
//   div  : step period minus one
//   tick : high when the counter has reached (or passed) div
module lamp_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so that lowering div below the running count ends
  // the step at once instead of wrapping through the whole counter range.
  assign tick = (cnt >= div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lamp_sequencer.sv
// lamp_sequencer: mode-selected lamp animation (idle / fill / chase / blink).
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   mode   : 00 idle, 01 fill, 10 chase, 11 blink; sampled every edge
//   div    : step period minus one (one animation step every div+1 cycles)
//   q      : registered lamp pattern
//   active : registered, high in every state except idle
//   tick   : step strobe, decoded from the prescaler count and the state
module lamp_sequencer
  import lamp_seq_pkg::*;
#(
  parameter int N_LAMPS = 4,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  output logic [N_LAMPS-1:0] q,
  output logic               active,
  output logic               tick
);

  localparam int POS_W = $clog2(N_LAMPS);
  localparam logic [N_LAMPS-1:0] LAMP_ONE = {{(N_LAMPS-1){1'b0}}, 1'b1};
  // Blink base pattern: the two end lamps lit.
  localparam logic [N_LAMPS-1:0] BLINK_E  = LAMP_ONE | (LAMP_ONE << (N_LAMPS-1));
  localparam logic [POS_W-1:0]   LAST_POS = POS_W'(N_LAMPS-1);

  state_t           state;
  state_t           mode_state;
  logic             mode_entry;
  logic             cnt_at_limit;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;
  logic             phase;

  assign mode_state = state_t'(mode);
  assign mode_entry = (mode_state != state);
  assign pos_next   = (pos == LAST_POS) ? '0 : pos + POS_W'(1);

  // The count is cleared on every mode entry (so entry beats a coincident
  // step) and held at zero while idle.
  lamp_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_entry || (state == S_IDLE)),
    .div  (div),
    .tick (cnt_at_limit)
  );

  // Gating with the state keeps tick low in idle and lets reset drop it
  // asynchronously together with the state register.
  assign tick = cnt_at_limit && (state != S_IDLE);

  function automatic logic [N_LAMPS-1:0] entry_pattern(input state_t s);
    case (s)
      S_FILL:  entry_pattern = '1;
      S_CHASE: entry_pattern = LAMP_ONE;
      S_BLINK: entry_pattern = BLINK_E;
      default: entry_pattern = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      q      <= '0;
      active <= 1'b0;
      pos    <= '0;
      phase  <= 1'b0;
    end else begin
      state  <= mode_state;
      active <= (mode_state != S_IDLE);
      if (mode_entry) begin
        pos   <= '0;
        phase <= 1'b0;
        q     <= entry_pattern(mode_state);
      end else if (tick) begin
        case (state)
          S_CHASE: begin
            pos <= pos_next;
            q   <= LAMP_ONE << pos_next;
          end
          S_BLINK: begin
            phase <= ~phase;
            // phase is the value being left, so the new pattern is its opposite
            q     <= phase ? BLINK_E : ~BLINK_E;
          end
          default: begin
            // idle and fill patterns are steady once loaded
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
module tb_lamp_sequencer;

  localparam int N_LAMPS = 4;
  localparam int DIV_W   = 8;

  logic               clk;
  logic               rst;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   div;
  logic [N_LAMPS-1:0] q;
  logic               active;
  logic               tick;

  lamp_sequencer #(
    .N_LAMPS (N_LAMPS),
    .DIV_W   (DIV_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .div    (div),
    .q      (q),
    .active (active),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current mode, cycles elapsed in the current step,
  // and number of steps taken since the mode was entered.
  int ref_mode = 0;
  int ref_cnt  = 0;
  int ref_step = 0;

  logic [3:0] obs_q;
  logic       obs_act;
  logic       obs_tick;
  logic       mdl_tick;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic [3:0] q;
    logic       act;
    logic       tick;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] model_q();
    case (ref_mode)
      1: model_q = 4'b1111;
      2: model_q = 4'b0001 << (ref_step % 4);
      3: model_q = ((ref_step % 2) == 1) ? 4'b0110 : 4'b1001;
      default: model_q = 4'b0000;
    endcase
  endfunction

  function automatic void model_reset();
    ref_mode = 0;
    ref_cnt  = 0;
    ref_step = 0;
  endfunction

  // One clock: drive inputs mid-cycle, sample tick before the edge, update
  // the model on the edge, sample q/active after it; all checked vs model.
  task automatic cycle(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    mode = m;
    div  = d;
    #1;
    obs_tick = tick;
    mdl_tick = (ref_mode != 0) && (ref_cnt >= int'(d));
    @(posedge clk);
    if (int'(m) != ref_mode) begin
      ref_mode = int'(m);
      ref_cnt  = 0;
      ref_step = 0;
    end else if (ref_mode == 0) begin
      ref_cnt = 0;
    end else if (ref_cnt >= int'(d)) begin
      ref_cnt = 0;
      ref_step++;
    end else begin
      ref_cnt++;
    end
    #1;
    obs_q   = q;
    obs_act = active;
    check("mdl_tick", {31'd0, obs_tick}, {31'd0, mdl_tick});
    check("mdl_q", {28'd0, obs_q}, {28'd0, model_q()});
    check("mdl_active", {31'd0, obs_act}, {31'd0, (ref_mode != 0)});
  endtask

  // Cycle plus explicit expected values for a hand-written step.
  task automatic step_chk(input string name, input logic [1:0] m, input logic [7:0] d,
                          input logic [3:0] eq, input logic ea, input logic et);
    cycle(m, d);
    check({name, "_tick"}, {31'd0, obs_tick}, {31'd0, et});
    check({name, "_q"}, {28'd0, obs_q}, {28'd0, eq});
    check({name, "_active"}, {31'd0, obs_act}, {31'd0, ea});
  endtask

  logic [1:0] r_mode;
  logic [7:0] r_div;

  initial begin
    // Chase at div=2, then blink at div=0, fill, idle.
    tbl[0]  = '{2'b10, 8'd2, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{2'b10, 8'd2, 4'b0001, 1'b1, 1'b0};
    tbl[2]  = '{2'b10, 8'd2, 4'b0001, 1'b1, 1'b0};
    tbl[3]  = '{2'b10, 8'd2, 4'b0010, 1'b1, 1'b1};
    tbl[4]  = '{2'b10, 8'd2, 4'b0010, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, 8'd2, 4'b0010, 1'b1, 1'b0};
    tbl[6]  = '{2'b10, 8'd2, 4'b0100, 1'b1, 1'b1};
    tbl[7]  = '{2'b10, 8'd2, 4'b0100, 1'b1, 1'b0};
    tbl[8]  = '{2'b10, 8'd2, 4'b0100, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 8'd2, 4'b1000, 1'b1, 1'b1};
    tbl[10] = '{2'b10, 8'd2, 4'b1000, 1'b1, 1'b0};
    tbl[11] = '{2'b10, 8'd2, 4'b1000, 1'b1, 1'b0};
    tbl[12] = '{2'b10, 8'd2, 4'b0001, 1'b1, 1'b1};
    tbl[13] = '{2'b11, 8'd0, 4'b1001, 1'b1, 1'b1};
    tbl[14] = '{2'b11, 8'd0, 4'b0110, 1'b1, 1'b1};
    tbl[15] = '{2'b11, 8'd0, 4'b1001, 1'b1, 1'b1};
    tbl[16] = '{2'b01, 8'd0, 4'b1111, 1'b1, 1'b1};
    tbl[17] = '{2'b00, 8'd0, 4'b0000, 1'b0, 1'b1};
    tbl[18] = '{2'b00, 8'd0, 4'b0000, 1'b0, 1'b0};

    rst  = 1'b0;
    mode = 2'b00;
    div  = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_q", {28'd0, q}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step_chk($sformatf("vec%0d", i), tbl[i].mode, tbl[i].div, tbl[i].q, tbl[i].act, tbl[i].tick);
      $display("[TB] vec %0d mode=%b div=%0d q=%b active=%b tick=%b", i, tbl[i].mode, tbl[i].div,
               obs_q, obs_act, obs_tick);
    end

    // Reset mid-animation: reach q=0100 in chase, then pull rst low between edges.
    step_chk("rstA0", 2'b10, 8'd2, 4'b0001, 1'b1, 1'b0);
    step_chk("rstA1", 2'b10, 8'd2, 4'b0001, 1'b1, 1'b0);
    step_chk("rstA2", 2'b10, 8'd2, 4'b0001, 1'b1, 1'b0);
    step_chk("rstA3", 2'b10, 8'd2, 4'b0010, 1'b1, 1'b1);
    step_chk("rstA4", 2'b10, 8'd2, 4'b0010, 1'b1, 1'b0);
    step_chk("rstA5", 2'b10, 8'd2, 4'b0010, 1'b1, 1'b0);
    step_chk("rstA6", 2'b10, 8'd2, 4'b0100, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_q", {28'd0, q}, 32'd0);
    check("async_rst_active", {31'd0, active}, 32'd0);
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    model_reset();
    @(negedge clk);
    mode = 2'b00;
    rst  = 1'b1;

    // Mode change restarts the animation.
    step_chk("mcB0", 2'b10, 8'd1, 4'b0001, 1'b1, 1'b0);
    step_chk("mcB1", 2'b10, 8'd1, 4'b0001, 1'b1, 1'b0);
    step_chk("mcB2", 2'b10, 8'd1, 4'b0010, 1'b1, 1'b1);
    step_chk("mcB3", 2'b10, 8'd1, 4'b0010, 1'b1, 1'b0);
    step_chk("mcB4", 2'b10, 8'd1, 4'b0100, 1'b1, 1'b1);
    step_chk("mcB5", 2'b11, 8'd1, 4'b1001, 1'b1, 1'b0);
    step_chk("mcB6", 2'b10, 8'd1, 4'b0001, 1'b1, 1'b0);
    step_chk("mcB7", 2'b10, 8'd1, 4'b0001, 1'b1, 1'b0);
    step_chk("mcB8", 2'b10, 8'd1, 4'b0010, 1'b1, 1'b1);

    // Fill holds all lamps lit for 20 cycles whatever div does.
    for (int i = 0; i < 20; i++) begin
      cycle(2'b01, 8'($urandom_range(0, 7)));
      check("fill_q", {28'd0, obs_q}, 32'h0000000f);
      check("fill_active", {31'd0, obs_act}, 32'd1);
    end

    // Div lowered below the running count: tick at once, then 2-cycle steps.
    cycle(2'b10, 8'd5);
    check("divD_entry_q", {28'd0, obs_q}, 32'h1);
    step_chk("divD1", 2'b10, 8'd5, 4'b0001, 1'b1, 1'b0);
    step_chk("divD2", 2'b10, 8'd5, 4'b0001, 1'b1, 1'b0);
    step_chk("divD3", 2'b10, 8'd5, 4'b0001, 1'b1, 1'b0);
    step_chk("divD4", 2'b10, 8'd1, 4'b0010, 1'b1, 1'b1);
    step_chk("divD5", 2'b10, 8'd1, 4'b0010, 1'b1, 1'b0);
    step_chk("divD6", 2'b10, 8'd1, 4'b0100, 1'b1, 1'b1);
    step_chk("divD7", 2'b10, 8'd1, 4'b0100, 1'b1, 1'b0);
    step_chk("divD8", 2'b10, 8'd1, 4'b1000, 1'b1, 1'b1);
    step_chk("divD9", 2'b00, 8'd1, 4'b0000, 1'b0, 1'b0);

    // Randomized run against the reference model.
    r_mode = 2'b10;
    r_div  = 8'd2;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) r_div = 8'($urandom_range(0, 4));
      cycle(r_mode, r_div);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
